// File: rtl/uart_packet_tx_arbiter.sv
// Two-requester packet arbiter in front of a byte-wide UART transmitter.
// A granted packet is latched and streamed LSB byte first, one tx_dv strobe
// per byte, waiting for tx_done between bytes with a per-byte timeout.
module uart_packet_tx_arbiter #(
  parameter int PACKET_BYTES = 18,
  parameter int LEN_W        = 5,
  parameter int TIMEOUT      = 4000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req0,
  input  logic                      req1,
  input  logic [8*PACKET_BYTES-1:0] data0,
  input  logic [8*PACKET_BYTES-1:0] data1,
  input  logic [LEN_W-1:0]          len0,
  input  logic [LEN_W-1:0]          len1,
  output logic                      done0,
  output logic                      done1,
  output logic                      error,
  output logic                      busy,
  output logic                      grant,
  output logic                      tx_dv,
  output logic [7:0]                tx_byte,
  input  logic                      tx_done,
  input  logic                      tx_active
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PACKET_BYTES);
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT, S_NEXT, S_DONE, S_ABORT
  } state_t;

  state_t                    state_q, state_d;
  logic                      grant_q, grant_d;
  logic                      last_q, last_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic [LEN_W-1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      tx_dv_q, tx_dv_d;
  logic [7:0]                tx_byte_q, tx_byte_d;
  logic                      done0_q, done0_d;
  logic                      done1_q, done1_d;
  logic                      error_q, error_d;
  logic                      busy_q, busy_d;
  logic [8*PACKET_BYTES-1:0] data_q;
  logic                      load_data;
  logic                      sel;

  // Zero or oversize lengths mean a full-size packet.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == '0 || l > MAX_LEN) return MAX_LEN;
    return l;
  endfunction

  // Next-state and next-output logic; pulse outputs coincide with the state
  // that owns them (tx_dv with the first WAIT cycle, done with DONE, error
  // with ABORT).
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    len_d     = len_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    tx_byte_d = tx_byte_q;
    tx_dv_d   = 1'b0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    error_d   = 1'b0;
    load_data = 1'b0;
    sel       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // Tie goes to whoever was not served last.
          sel       = (req0 && req1) ? ~last_q : req1;
          grant_d   = sel;
          len_d     = clamp_len(sel ? len1 : len0);
          idx_d     = '0;
          cnt_d     = '0;
          load_data = 1'b1;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!tx_active) begin
          tx_byte_d = data_q[8*int'(idx_q) +: 8];
          tx_dv_d   = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tx_done) begin
          cnt_d   = '0;
          state_d = S_NEXT;
        end else if (cnt_q == TO_LIM) begin
          error_d = 1'b1;
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_NEXT: begin
        if (({1'b0, idx_q} + (LEN_W+1)'(1)) == {1'b0, len_q}) begin
          done0_d = ~grant_q;
          done1_d = grant_q;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        last_d  = grant_q;
        state_d = S_IDLE;
      end
      S_ABORT: begin
        last_d  = grant_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Control state and registered outputs; reset aborts any transfer silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      len_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      error_q   <= error_d;
      busy_q    <= busy_d;
    end
  end

  // Packet payload capture at grant; payload needs no reset.
  always_ff @(posedge clk) begin
    if (load_data) data_q <= sel ? data1 : data0;
  end

  assign done0   = done0_q;
  assign done1   = done1_q;
  assign error   = error_q;
  assign busy    = busy_q;
  assign grant   = grant_q;
  assign tx_dv   = tx_dv_q;
  assign tx_byte = tx_byte_q;

endmodule

// File: tb/tb_uart_packet_tx_arbiter.sv
// Directed self-checking bench for uart_packet_tx_arbiter with a simple
// uart_tx model that answers tx_dv with tx_done ten cycles later.
module tb_uart_packet_tx_arbiter;
  localparam int PB = 18;
  localparam int LW = 5;
  localparam int TO = 100;

  logic            clk = 1'b0;
  logic            reset;
  logic            req0, req1;
  logic [8*PB-1:0] data0, data1;
  logic [LW-1:0]   len0, len1;
  logic            done0, done1, error, busy, grant, tx_dv;
  logic [7:0]      tx_byte;
  logic            tx_done, tx_active;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  logic [7:0] mon_q[$];
  int d0_cnt, d1_cnt, err_cnt;
  int last_dv_cyc, err_cyc;
  int m_cnt = 0;
  int withhold_idx = -1;

  uart_packet_tx_arbiter #(.PACKET_BYTES(PB), .LEN_W(LW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .data0(data0), .data1(data1), .len0(len0), .len1(len1),
    .done0(done0), .done1(done1), .error(error), .busy(busy), .grant(grant),
    .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_done(tx_done), .tx_active(tx_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: records strobed bytes and output pulses on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_dv === 1'b1) begin
        mon_q.push_back(tx_byte);
        last_dv_cyc = cyc;
      end
      if (done0 === 1'b1) d0_cnt++;
      if (done1 === 1'b1) d1_cnt++;
      if (error === 1'b1) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
  end

  // uart_tx model: tx_done is sampled by the DUT 10 edges after tx_dv.
  initial begin
    tx_done = 1'b0;
    forever begin
      int idx;
      @(posedge clk); #1;
      if (tx_dv === 1'b1) begin
        idx = m_cnt;
        m_cnt++;
        repeat (9) @(posedge clk);
        #1;
        if (idx != withhold_idx) begin
          tx_done = 1'b1;
          @(posedge clk); #1;
          tx_done = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input int wh);
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0; tx_active = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mon_q.delete();
    d0_cnt = 0; d1_cnt = 0; err_cnt = 0;
    m_cnt = 0;
    withhold_idx = wh;
    reset = 1'b1;
  endtask

  task automatic wait_end(input int maxc, output logic [2:0] ev, output logic g);
    ev = 3'b000;
    g  = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk); #1;
      if ({error, done1, done0} != 3'b000) begin
        ev = {error, done1, done0};
        g  = grant;
        return;
      end
    end
    check("wait_timeout", 1, 0);
  endtask

  initial begin
    logic [2:0] ev;
    logic       g;
    int         bad;
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0; tx_active = 1'b0;
    data0 = '0; data1 = '0; len0 = '0; len1 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_tx_dv", tx_dv, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_grant", grant, 0);
    check("rst_done", {done1, done0}, 0);
    check("rst_error", error, 0);

    // Full 18-byte packet on requester 0, first-strobe latency
    do_reset(-1);
    for (int k = 0; k < PB; k++) data0[8*k +: 8] = 8'(k);
    len0 = 5'd18;
    req0 = 1'b1;
    @(posedge clk); #1;
    check("s1_busy", busy, 1);
    check("s1_dv_early", tx_dv, 0);
    @(posedge clk); #1;
    check("s1_dv_first", tx_dv, 1);
    check("s1_byte0", tx_byte, 8'h00);
    wait_end(2000, ev, g);
    req0 = 1'b0;
    check("s1_event", ev, 3'b001);
    check("s1_grant", g, 0);
    check("s1_nbytes", mon_q.size(), 18);
    bad = 0;
    for (int k = 0; k < PB; k++)
      if (k >= mon_q.size() || mon_q[k] !== 8'(k)) bad++;
    check("s1_order", bad, 0);
    check("s1_byte_hold", tx_byte, 8'h11);
    @(negedge clk);
    check("s1_done_cnts", {d0_cnt[7:0], d1_cnt[7:0], err_cnt[7:0]}, {8'd1, 8'd0, 8'd0});

    // Round robin: simultaneous requests twice
    do_reset(-1);
    len0 = 5'd2; len1 = 5'd2;
    req0 = 1'b1; req1 = 1'b1;
    for (int rep = 0; rep < 2; rep++) begin
      for (int j = 0; j < 2; j++) begin
        wait_end(500, ev, g);
        check($sformatf("rr_grant_%0d_%0d", rep, j), g, j);
        check($sformatf("rr_done_%0d_%0d", rep, j), ev, (j == 1) ? 3'b010 : 3'b001);
        if (g) req1 = 1'b0; else req0 = 1'b0;
      end
      if (rep == 0) begin
        req0 = 1'b1; req1 = 1'b1;
      end
    end
    check("rr_nbytes", mon_q.size(), 8);

    // Length 0 and length 25 both mean 18 bytes
    do_reset(-1);
    for (int k = 0; k < PB; k++) data1[8*k +: 8] = 8'(8'hA0 + k);
    len1 = 5'd0;
    req1 = 1'b1;
    wait_end(2000, ev, g);
    req1 = 1'b0;
    check("len0_event", ev, 3'b010);
    check("len0_nbytes", mon_q.size(), 18);
    repeat (2) @(posedge clk);
    #1;
    mon_q.delete();
    len1 = 5'd25;
    req1 = 1'b1;
    wait_end(2000, ev, g);
    req1 = 1'b0;
    check("len25_event", ev, 3'b010);
    check("len25_nbytes", mon_q.size(), 18);
    if (mon_q.size() == 18) check("len25_last", mon_q[17], 8'hB1);

    // Timeout: tx_done withheld for the byte after the third
    do_reset(3);
    len0 = 5'd5;
    req0 = 1'b1;
    wait_end(1000, ev, g);
    req0 = 1'b0;
    check("to_event", ev, 3'b100);
    @(negedge clk);
    check("to_latency", err_cyc - last_dv_cyc, 101);
    check("to_busy_at_err", busy, 1);
    @(posedge clk); #1;
    check("to_busy_after", busy, 0);
    check("to_nbytes", mon_q.size(), 4);
    check("to_no_done", d0_cnt + d1_cnt, 0);

    // Asynchronous reset during the fifth byte, then requester 1
    do_reset(-1);
    for (int k = 0; k < PB; k++) data0[8*k +: 8] = 8'(8'h30 + k);
    len0 = 5'd18;
    req0 = 1'b1;
    begin
      int n = 0;
      while (mon_q.size() < 5 && n < 500) begin
        @(negedge clk);
        n++;
      end
      check("ar_reach_5th", mon_q.size() >= 5, 1);
    end
    #3 reset = 1'b0;
    #1;
    check("ar_busy", busy, 0);
    check("ar_tx_byte", tx_byte, 0);
    check("ar_pulses", {tx_dv, done0, done1, error, grant}, 0);
    repeat (15) @(posedge clk);
    #1;
    req0 = 1'b0; req1 = 1'b1;
    len1 = 5'd3;
    for (int k = 0; k < PB; k++) data1[8*k +: 8] = 8'(8'h50 + k);
    mon_q.delete();
    m_cnt = 0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("ar_resume_busy", busy, 1);
    check("ar_resume_grant", grant, 1);
    wait_end(500, ev, g);
    req1 = 1'b0;
    check("ar_event", ev, 3'b010);
    check("ar_nbytes", mon_q.size(), 3);
    if (mon_q.size() > 0) check("ar_byte0", mon_q[0], 8'h50);
    check("ar_no_stale", d0_cnt + err_cnt, 0);

    // tx_active held high at grant delays the first strobe
    do_reset(-1);
    data0[7:0] = 8'h77;
    len0 = 5'd1;
    tx_active = 1'b1;
    req0 = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("act_busy", busy, 1);
    check("act_dv_held", tx_dv, 0);
    check("act_no_strobe", mon_q.size(), 0);
    tx_active = 1'b0;
    @(posedge clk); #1;
    check("act_dv", tx_dv, 1);
    check("act_byte", tx_byte, 8'h77);
    wait_end(200, ev, g);
    req0 = 1'b0;
    check("act_event", ev, 3'b001);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
